// File: rtl/array_rfsh_sched.sv
// Refresh scheduler: turns the programmed start/period into refresh ticks, banks them
// as postponement credit, and handshakes one refresh at a time with the array FSM.
module array_rfsh_sched #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int MAX_PEND       = 8,
  parameter int URGENT_TH      = 6,
  parameter int PEND_W         = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mc_en,
  input  logic [APB_DATA_WIDTH-1:0] mc_refresh_period,
  input  logic [APB_DATA_WIDTH-1:0] mc_refresh_start,
  output logic                      rfsh_req,
  output logic                      rfsh_urgent,
  input  logic                      rfsh_grant,
  input  logic                      rfsh_end,
  output logic [PEND_W-1:0]         rfsh_pending,
  output logic                      rfsh_overflow
);

  localparam logic [APB_DATA_WIDTH-1:0] ONE    = APB_DATA_WIDTH'(1);
  localparam logic [PEND_W-1:0]         PMAX   = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0]         PURGENT = PEND_W'(URGENT_TH);

  typedef enum logic [1:0] {IDLE, WAIT_START, RUN, BUSY} state_t;

  state_t                    state;
  logic [APB_DATA_WIDTH-1:0] timer;
  logic [APB_DATA_WIDTH-1:0] timer_nxt;
  logic [PEND_W-1:0]         pend_nxt;
  logic                      start_hit;
  logic                      period_hit;
  logic                      tick;
  logic                      done;
  logic                      ovf_set;

  // Saturating credit update; a tick and a completion in the same cycle cancel out.
  function automatic logic [PEND_W-1:0] next_pend(input logic [PEND_W-1:0] pend,
                                                  input logic inc, input logic dec);
    logic [PEND_W-1:0] res;
    res = pend;
    if (inc && !dec && pend < PMAX) res = pend + 1'b1;
    else if (dec && !inc)           res = pend - 1'b1;
    return res;
  endfunction

  // start=0 must tick immediately, so it is not compared as start-1 (which would wrap).
  assign start_hit  = (mc_refresh_start == '0) || (timer >= mc_refresh_start - ONE);
  assign period_hit = (mc_refresh_period != '0) && (timer >= mc_refresh_period - ONE);
  assign done       = (state == BUSY) && rfsh_end;
  assign timer_nxt  = tick ? '0 : timer + ONE;

  always_comb begin
    tick = 1'b0;
    case (state)
      WAIT_START: tick = mc_en && start_hit;
      RUN:        tick = mc_en && period_hit;
      BUSY:       tick = mc_en && period_hit;
      default:    tick = 1'b0;
    endcase
  end

  assign pend_nxt = next_pend(rfsh_pending, tick, done);
  assign ovf_set  = tick && !done && (rfsh_pending >= PMAX);

  assign rfsh_req    = (rfsh_pending != '0) && (state != BUSY) && mc_en;
  assign rfsh_urgent = (rfsh_pending >= PURGENT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      rfsh_pending  <= '0;
      rfsh_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer         <= '0;
          rfsh_pending  <= '0;
          rfsh_overflow <= 1'b0;
          if (mc_en) state <= WAIT_START;
        end
        WAIT_START: begin
          if (!mc_en) begin
            state        <= IDLE;
            timer        <= '0;
            rfsh_pending <= '0;
          end else begin
            timer        <= timer_nxt;
            rfsh_pending <= pend_nxt;
            if (ovf_set) rfsh_overflow <= 1'b1;
            if (tick)    state <= RUN;
          end
        end
        RUN: begin
          if (!mc_en) begin
            state        <= IDLE;
            timer        <= '0;
            rfsh_pending <= '0;
          end else begin
            timer        <= timer_nxt;
            rfsh_pending <= pend_nxt;
            if (ovf_set)              rfsh_overflow <= 1'b1;
            if (rfsh_req && rfsh_grant) state <= BUSY;
          end
        end
        BUSY: begin
          // With the enable gone, the refresh in flight still finishes before idling.
          if (done && !mc_en) begin
            state        <= IDLE;
            timer        <= '0;
            rfsh_pending <= '0;
          end else begin
            timer        <= timer_nxt;
            rfsh_pending <= pend_nxt;
            if (ovf_set) rfsh_overflow <= 1'b1;
            if (done)    state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_rfsh_sched.sv
// Directed bench for array_rfsh_sched: a vector table for the free-running tick
// sequence plus hand-written sequences for the handshake and enable/reset corners.
module tb_array_rfsh_sched;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mc_en;
  logic [W-1:0] mc_refresh_period;
  logic [W-1:0] mc_refresh_start;
  logic         rfsh_req;
  logic         rfsh_urgent;
  logic         rfsh_grant;
  logic         rfsh_end;
  logic [3:0]   rfsh_pending;
  logic         rfsh_overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] pend;
    logic       req;
    logic       urg;
    logic       ovf;
  } vec_t;

  vec_t tbl [10];

  array_rfsh_sched #(
    .APB_DATA_WIDTH(W),
    .MAX_PEND(8),
    .URGENT_TH(6),
    .PEND_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mc_en(mc_en),
    .mc_refresh_period(mc_refresh_period),
    .mc_refresh_start(mc_refresh_start),
    .rfsh_req(rfsh_req),
    .rfsh_urgent(rfsh_urgent),
    .rfsh_grant(rfsh_grant),
    .rfsh_end(rfsh_end),
    .rfsh_pending(rfsh_pending),
    .rfsh_overflow(rfsh_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int p, input int r, input int u, input int o);
    check({tag, ".pending"},  32'(rfsh_pending),  32'(p));
    check({tag, ".req"},      32'(rfsh_req),      32'(r));
    check({tag, ".urgent"},   32'(rfsh_urgent),   32'(u));
    check({tag, ".overflow"}, 32'(rfsh_overflow), 32'(o));
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Cycle 0 is the first cycle spent in WAIT_START with the timer at zero.
  task automatic enable();
    mc_en = 1'b1;
    cyc   = -1;
    step();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    mc_en      = 1'b0;
    rfsh_grant = 1'b0;
    rfsh_end   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // start=10, period=100, no grants: ticks at cycles 9,109,...; visible one cycle later
    tbl[0] = '{0,   4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{9,   4'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{10,  4'd1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{109, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{110, 4'd2, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{509, 4'd5, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{510, 4'd6, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{710, 4'd8, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{809, 4'd8, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{810, 4'd8, 1'b1, 1'b1, 1'b1};

    mc_refresh_start  = 32'd10;
    mc_refresh_period = 32'd100;
    do_reset();
    expect_out("reset", 0, 0, 0, 0);

    enable();
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].cyc);
      expect_out($sformatf("accum%0d", i), tbl[i].pend, tbl[i].req, tbl[i].urg, tbl[i].ovf);
    end
    // Disable: pending clears on leaving RUN, overflow clears once in IDLE.
    mc_en = 1'b0;
    step();
    check("dis.pending", 32'(rfsh_pending), 32'd0);
    check("dis.overflow_held", 32'(rfsh_overflow), 32'd1);
    step();
    check("dis.overflow_clr", 32'(rfsh_overflow), 32'd0);

    // Grant/end handshake and undisturbed tick spacing.
    do_reset();
    enable();
    run_to(5);
    rfsh_grant = 1'b1;            // no request yet: must be ignored
    step();
    rfsh_grant = 1'b0;
    run_to(10);
    check("hs.req_first", 32'(rfsh_req), 32'd1);
    rfsh_grant = 1'b1;
    step();
    rfsh_grant = 1'b0;
    check("hs.req_busy", 32'(rfsh_req), 32'd0);
    check("hs.pend_busy", 32'(rfsh_pending), 32'd1);
    run_to(15);
    check("hs.req_busy_late", 32'(rfsh_req), 32'd0);
    rfsh_end = 1'b1;
    step();
    rfsh_end = 1'b0;
    check("hs.pend_done", 32'(rfsh_pending), 32'd0);
    check("hs.req_done", 32'(rfsh_req), 32'd0);
    run_to(109);
    check("hs.pend_pre_tick", 32'(rfsh_pending), 32'd0);
    step();
    check("hs.pend_tick2", 32'(rfsh_pending), 32'd1);
    rfsh_grant = 1'b1;
    step();
    rfsh_grant = 1'b0;
    run_to(115);
    rfsh_end = 1'b1;
    step();
    rfsh_end = 1'b0;
    check("hs.pend_done2", 32'(rfsh_pending), 32'd0);

    // Tick and rfsh_end coincide while pending is at MAX_PEND.
    do_reset();
    enable();
    run_to(710);
    expect_out("full", 8, 1, 1, 0);
    rfsh_grant = 1'b1;
    step();
    rfsh_grant = 1'b0;
    check("full.req_busy", 32'(rfsh_req), 32'd0);
    run_to(809);
    rfsh_end = 1'b1;
    step();
    rfsh_end = 1'b0;
    expect_out("coincide", 8, 1, 1, 0);

    // Enable dropped mid-refresh, then restart.
    do_reset();
    mc_refresh_start  = 32'd3;
    mc_refresh_period = 32'd50;
    enable();
    run_to(3);
    check("drop.req", 32'(rfsh_req), 32'd1);
    rfsh_grant = 1'b1;
    step();
    rfsh_grant = 1'b0;
    mc_en = 1'b0;
    step();
    check("drop.busy_pend5", 32'(rfsh_pending), 32'd1);
    step();
    check("drop.busy_pend6", 32'(rfsh_pending), 32'd1);
    rfsh_end = 1'b1;
    step();
    rfsh_end = 1'b0;
    expect_out("drop.idle", 0, 0, 0, 0);
    mc_en = 1'b1;
    run_to(10);
    check("reen.pend_pre", 32'(rfsh_pending), 32'd0);
    step();
    check("reen.pend", 32'(rfsh_pending), 32'd1);
    check("reen.req", 32'(rfsh_req), 32'd1);

    // Asynchronous reset in the middle of a refresh.
    rfsh_grant = 1'b1;
    step();
    rfsh_grant = 1'b0;
    check("arst.busy_pend", 32'(rfsh_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1 expect_out("arst", 0, 0, 0, 0);

    // start=0 ticks in the first WAIT_START cycle; period=0 never ticks again.
    mc_refresh_start  = 32'd0;
    mc_refresh_period = 32'd0;
    mc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    enable();
    check("p0.pend_c0", 32'(rfsh_pending), 32'd0);
    step();
    check("p0.pend_c1", 32'(rfsh_pending), 32'd1);
    run_to(300);
    expect_out("p0.hold", 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
